mem_port_arbiter: RTL and testbench

- Shares one single-ported instruction/data memory between the instruction-fetch requester and the load/store requester of the control unit.
- Both requesters use the same req/gnt/r_valid handshake. The arbiter serialises them onto one downstream port with at most one outstanding transaction.
- Sits between the control unit/datapath and the unified memory model. Each requester sees an unchanged interface.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter_select.sv | 39 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants for the memory port arbiter: FSM state codes, the owner
// encoding used by the winner selection and the last_owner pointer, and the
// default address/data widths of all ports.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // FSM state codes
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ_I = 3'd1;
    localparam logic [2:0] REQ_D = 3'd2;
    localparam logic [2:0] RSP_I = 3'd3;
    localparam logic [2:0] RSP_D = 3'd4;

    // Owner encoding
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// One req/gnt/r_valid memory port. The same interface type is used for the
// fetch port, the load/store port and the downstream memory port.
//   req     : request, held until gnt
//   addr    : address
//   we      : 0 = read, 1 = write (tied to 0 on the fetch port)
//   wdata   : write data (tied to 0 on the fetch port)
//   gnt     : request accepted
//   r_valid : response valid (reads and writes)
//   rdata   : read data
// Modports: master = issues requests, slave = accepts requests.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              r_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, addr, we, wdata,
        input  gnt, r_valid, rdata
    );

    modport slave (
        input  req, addr, we, wdata,
        output gnt, r_valid, rdata
    );
endinterface

// File: rtl/mem_port_arbiter_select.sv
// ---------------------------------------------------------------------------
// mem_arb_select
// Combinational winner selection for the IDLE state.
//   instr_req  : fetch request
//   data_req   : load/store request
//   last_owner : port granted most recently (only with MEM_PORT_ARBITER_RR_EN)
//   any_req    : at least one request present
//   winner     : OWN_I or OWN_D
// Macro MEM_PORT_ARBITER_RR_EN selects round-robin on simultaneous requests;
// without it data always beats instr.
// ---------------------------------------------------------------------------
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic instr_req,
    input  logic data_req,
`ifdef MEM_PORT_ARBITER_RR_EN
    input  logic last_owner,
`endif
    output logic any_req,
    output logic winner
);

    assign any_req = instr_req | data_req;

`ifdef MEM_PORT_ARBITER_RR_EN
    // On a tie the port that did not win last time goes first.
    always_comb begin
        if (instr_req && data_req) begin
            winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else begin
            winner = data_req ? OWN_D : OWN_I;
        end
    end
`else
    assign winner = data_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Serialises the fetch and load/store requesters onto one single-ported
// memory with at most one outstanding transaction.
//   CLK        : clock, rising edge
//   RES_N      : asynchronous active-low reset; all outputs forced to 0
//   instr_port : fetch requester (slave side)
//   data_port  : load/store requester (slave side)
//   mem_port   : downstream memory (master side)
// Optional macro MEM_PORT_ARBITER_RR_EN: round-robin arbitration using a
// last_owner register; default is fixed priority data > instr.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               CLK,
    input  logic               RES_N,
    mem_port_arbiter_if.slave  instr_port,
    mem_port_arbiter_if.slave  data_port,
    mem_port_arbiter_if.master mem_port
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              any_req;
    logic              winner;
    logic              issue;
    logic              issue_owner;

    logic              mem_req_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              mem_we_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              instr_gnt_c;
    logic              data_gnt_c;
    logic              instr_r_valid_c;
    logic              data_r_valid_c;
    logic [DATA_W-1:0] instr_rdata_c;
    logic [DATA_W-1:0] data_rdata_c;

`ifdef MEM_PORT_ARBITER_RR_EN
    logic last_owner;
`endif

    mem_arb_select u_select (
        .instr_req  (instr_port.req),
        .data_req   (data_port.req),
`ifdef MEM_PORT_ARBITER_RR_EN
        .last_owner (last_owner),
`endif
        .any_req    (any_req),
        .winner     (winner)
    );

    // Next-state and output decode. IDLE and REQ_x share the request path:
    // in IDLE the owner is the fresh winner, in REQ_x it is the locked one.
    always_comb begin
        state_nxt       = state;
        issue           = 1'b0;
        issue_owner     = OWN_I;
        mem_req_c       = 1'b0;
        mem_addr_c      = '0;
        mem_we_c        = 1'b0;
        mem_wdata_c     = '0;
        instr_gnt_c     = 1'b0;
        data_gnt_c      = 1'b0;
        instr_r_valid_c = 1'b0;
        data_r_valid_c  = 1'b0;
        instr_rdata_c   = '0;
        data_rdata_c    = '0;

        case (state)
            IDLE: begin
                issue       = any_req;
                issue_owner = winner;
            end
            REQ_I: begin
                issue       = 1'b1;
                issue_owner = OWN_I;
            end
            REQ_D: begin
                issue       = 1'b1;
                issue_owner = OWN_D;
            end
            RSP_I: begin
                instr_r_valid_c = mem_port.r_valid;
                instr_rdata_c   = mem_port.rdata;
                if (mem_port.r_valid) begin
                    state_nxt = IDLE;
                end
            end
            RSP_D: begin
                data_r_valid_c = mem_port.r_valid;
                data_rdata_c   = mem_port.rdata;
                if (mem_port.r_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (issue) begin
            mem_req_c = 1'b1;
            if (issue_owner == OWN_D) begin
                mem_addr_c  = data_port.addr;
                mem_we_c    = data_port.we;
                mem_wdata_c = data_port.wdata;
                data_gnt_c  = mem_port.gnt;
                state_nxt   = mem_port.gnt ? RSP_D : REQ_D;
            end else begin
                mem_addr_c  = instr_port.addr;
                instr_gnt_c = mem_port.gnt;
                state_nxt   = mem_port.gnt ? RSP_I : REQ_I;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef MEM_PORT_ARBITER_RR_EN
    // Remember who was granted last so a tie goes to the other port.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            last_owner <= OWN_I;
        end else if (data_gnt_c) begin
            last_owner <= OWN_D;
        end else if (instr_gnt_c) begin
            last_owner <= OWN_I;
        end
    end
`endif

    // Outputs are forced low combinationally while reset is asserted.
    assign mem_port.req       = mem_req_c & RES_N;
    assign mem_port.addr      = mem_addr_c & {ADDR_W{RES_N}};
    assign mem_port.we        = mem_we_c & RES_N;
    assign mem_port.wdata     = mem_wdata_c & {DATA_W{RES_N}};
    assign instr_port.gnt     = instr_gnt_c & RES_N;
    assign instr_port.r_valid = instr_r_valid_c & RES_N;
    assign instr_port.rdata   = instr_rdata_c & {DATA_W{RES_N}};
    assign data_port.gnt      = data_gnt_c & RES_N;
    assign data_port.r_valid  = data_r_valid_c & RES_N;
    assign data_port.rdata    = data_rdata_c & {DATA_W{RES_N}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Inputs are driven 1 ns after the
// rising edge, outputs are checked 1 ns later, well before the next edge.
// Grant-order expectations follow MEM_PORT_ARBITER_RR_EN.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic CLK;
    logic RES_N;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) instr_if ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK        (CLK),
        .RES_N      (RES_N),
        .instr_port (instr_if.slave),
        .data_port  (data_if.slave),
        .mem_port   (mem_if.master)
    );

    // 100 MHz clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive every requester and memory input, then let logic settle.
    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [31:0] daddr,
                                 input logic dwe, input logic [31:0] dwdata,
                                 input logic mgnt, input logic mrv,
                                 input logic [31:0] mrdata);
        instr_if.req   = ireq;
        instr_if.addr  = iaddr;
        data_if.req    = dreq;
        data_if.addr   = daddr;
        data_if.we     = dwe;
        data_if.wdata  = dwdata;
        mem_if.gnt     = mgnt;
        mem_if.r_valid = mrv;
        mem_if.rdata   = mrdata;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_req"},    {63'd0, mem_if.req}, 64'd0);
        checkOutput({tag, "_mem_addr"},   {32'd0, mem_if.addr}, 64'd0);
        checkOutput({tag, "_mem_we"},     {63'd0, mem_if.we}, 64'd0);
        checkOutput({tag, "_mem_wdata"},  {32'd0, mem_if.wdata}, 64'd0);
        checkOutput({tag, "_i_gnt"},      {63'd0, instr_if.gnt}, 64'd0);
        checkOutput({tag, "_i_rvalid"},   {63'd0, instr_if.r_valid}, 64'd0);
        checkOutput({tag, "_i_rdata"},    {32'd0, instr_if.rdata}, 64'd0);
        checkOutput({tag, "_d_gnt"},      {63'd0, data_if.gnt}, 64'd0);
        checkOutput({tag, "_d_rvalid"},   {63'd0, data_if.r_valid}, 64'd0);
        checkOutput({tag, "_d_rdata"},    {32'd0, data_if.rdata}, 64'd0);
    endtask

    logic exp_d;

    initial begin
        total = 0;
        bad   = 0;
        instr_if.we    = 1'b0;
        instr_if.wdata = '0;
        RES_N = 1'b0;

        // Reset: outputs low even with requests and memory grant present
        applyStimulus(1, 32'h10, 1, 32'h100, 1, 32'hFFFF_FFFF, 1, 1, 32'h1234_5678);
        checkAllZero("reset");
        nextCycle();
        RES_N = 1'b1;

        // Test 1: instr-only, immediate grant, response two cycles later
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("t1_mem_req",  {63'd0, mem_if.req}, 64'd1);
        checkOutput("t1_mem_addr", {32'd0, mem_if.addr}, 64'h10);
        checkOutput("t1_mem_we",   {63'd0, mem_if.we}, 64'd0);
        checkOutput("t1_i_gnt",    {63'd0, instr_if.gnt}, 64'd1);
        checkOutput("t1_d_gnt",    {63'd0, data_if.gnt}, 64'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c1_mem_req", {63'd0, mem_if.req}, 64'd0);
        checkOutput("t1_c1_i_rvalid", {63'd0, instr_if.r_valid}, 64'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h00A0_0093);
        checkOutput("t1_i_rvalid", {63'd0, instr_if.r_valid}, 64'd1);
        checkOutput("t1_i_rdata",  {32'd0, instr_if.rdata}, 64'h00A0_0093);
        checkOutput("t1_d_rvalid", {63'd0, data_if.r_valid}, 64'd0);
        checkOutput("t1_d_rdata",  {32'd0, data_if.rdata}, 64'd0);
        nextCycle();

        // Test 2: simultaneous requests, data wins, instr after bubble
        applyStimulus(1, 32'h20, 1, 32'h100, 1, 32'hDEAD_BEEF, 1, 0, 0);
        checkOutput("t2_d_gnt",     {63'd0, data_if.gnt}, 64'd1);
        checkOutput("t2_i_gnt",     {63'd0, instr_if.gnt}, 64'd0);
        checkOutput("t2_mem_addr",  {32'd0, mem_if.addr}, 64'h100);
        checkOutput("t2_mem_we",    {63'd0, mem_if.we}, 64'd1);
        checkOutput("t2_mem_wdata", {32'd0, mem_if.wdata}, 64'hDEAD_BEEF);
        nextCycle();
        applyStimulus(1, 32'h20, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("t2_d_rvalid",  {63'd0, data_if.r_valid}, 64'd1);
        checkOutput("t2_bubble_i_gnt", {63'd0, instr_if.gnt}, 64'd0);
        checkOutput("t2_bubble_mem_req", {63'd0, mem_if.req}, 64'd0);
        nextCycle();
        applyStimulus(1, 32'h20, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("t2_i_gnt2",    {63'd0, instr_if.gnt}, 64'd1);
        checkOutput("t2_mem_addr2", {32'd0, mem_if.addr}, 64'h20);
        checkOutput("t2_mem_we2",   {63'd0, mem_if.we}, 64'd0);
        checkOutput("t2_mem_wdata2", {32'd0, mem_if.wdata}, 64'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001);
        checkOutput("t2_i_rvalid",  {63'd0, instr_if.r_valid}, 64'd1);
        checkOutput("t2_i_rdata",   {32'd0, instr_if.rdata}, 64'hCAFE_0001);
        nextCycle();

        // Test 3: locking while memory delays its grant
        applyStimulus(1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_c0_mem_req", {63'd0, mem_if.req}, 64'd1);
        checkOutput("t3_c0_i_gnt",   {63'd0, instr_if.gnt}, 64'd0);
        for (int c = 1; c <= 2; c++) begin
            nextCycle();
            applyStimulus(1, 32'h44, 1, 32'h200, 0, 0, 0, 0, 0);
            checkOutput("t3_lock_mem_addr", {32'd0, mem_if.addr}, 64'h44);
            checkOutput("t3_lock_d_gnt",    {63'd0, data_if.gnt}, 64'd0);
            checkOutput("t3_lock_i_gnt",    {63'd0, instr_if.gnt}, 64'd0);
        end
        nextCycle();
        applyStimulus(1, 32'h44, 1, 32'h200, 0, 0, 1, 0, 0);
        checkOutput("t3_c3_i_gnt",    {63'd0, instr_if.gnt}, 64'd1);
        checkOutput("t3_c3_d_gnt",    {63'd0, data_if.gnt}, 64'd0);
        checkOutput("t3_c3_mem_addr", {32'd0, mem_if.addr}, 64'h44);
        nextCycle();
        applyStimulus(0, 0, 1, 32'h200, 0, 0, 0, 1, 32'h0000_0013);
        checkOutput("t3_i_rvalid", {63'd0, instr_if.r_valid}, 64'd1);
        checkOutput("t3_rsp_d_gnt", {63'd0, data_if.gnt}, 64'd0);
        nextCycle();
        applyStimulus(0, 0, 1, 32'h200, 0, 0, 1, 0, 0);
        checkOutput("t3_d_gnt",  {63'd0, data_if.gnt}, 64'd1);
        checkOutput("t3_d_addr", {32'd0, mem_if.addr}, 64'h200);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);
        checkOutput("t3_d_rvalid", {63'd0, data_if.r_valid}, 64'd1);
        checkOutput("t3_d_rdata",  {32'd0, data_if.rdata}, 64'h0BAD_F00D);
        checkOutput("t3_i_rvalid_off", {63'd0, instr_if.r_valid}, 64'd0);
        nextCycle();

        // Test 5: reset during RSP_D, stale response afterwards
        applyStimulus(0, 0, 1, 32'h300, 0, 0, 1, 0, 0);
        checkOutput("t5_d_gnt", {63'd0, data_if.gnt}, 64'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        RES_N = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        checkAllZero("t5_rst");
        nextCycle();
        RES_N = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        checkOutput("t5_stale_d_rvalid", {63'd0, data_if.r_valid}, 64'd0);
        checkOutput("t5_stale_i_rvalid", {63'd0, instr_if.r_valid}, 64'd0);
        checkOutput("t5_stale_d_rdata",  {32'd0, data_if.rdata}, 64'd0);
        nextCycle();
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("t5_i_gnt",    {63'd0, instr_if.gnt}, 64'd1);
        checkOutput("t5_mem_addr", {32'd0, mem_if.addr}, 64'h80);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
        checkOutput("t5_i_rvalid", {63'd0, instr_if.r_valid}, 64'd1);
        checkOutput("t5_i_rdata",  {32'd0, instr_if.rdata}, 64'h1234);
        nextCycle();

        // Test 4: both ports request continuously for four transactions
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            applyStimulus(1, 32'h400, 1, 32'h500, 0, 0, 1, 0, 0);
            checkOutput("t4_d_gnt", {63'd0, data_if.gnt}, {63'd0, exp_d});
            checkOutput("t4_i_gnt", {63'd0, instr_if.gnt}, {63'd0, ~exp_d});
            checkOutput("t4_mem_addr", {32'd0, mem_if.addr},
                        exp_d ? 64'h500 : 64'h400);
            nextCycle();
            applyStimulus(1, 32'h400, 1, 32'h500, 0, 0, 1, 1, 32'hA0 + t);
            checkOutput("t4_d_rvalid", {63'd0, data_if.r_valid}, {63'd0, exp_d});
            checkOutput("t4_i_rvalid", {63'd0, instr_if.r_valid}, {63'd0, ~exp_d});
            checkOutput("t4_rsp_gnts", {62'd0, instr_if.gnt, data_if.gnt}, 64'd0);
            nextCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
